// File: rtl/ula_8_bits_controller.sv
// Sequencing controller for an external 8-bit ALU: accepts commands, holds the
// accumulator, and returns results. Define ULA_CARRY_CHAIN_EN for multi-byte carry chaining.
module ula_8_bits_controller #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic [7:0] ula_a,
    output logic [7:0] ula_b,
    output logic [2:0] ula_x,
    output logic       ula_cin,
    input  logic [7:0] ula_s,
    input  logic       ula_cout,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_cout,
    output logic       res_zero,
    output logic       res_err
);

    // state | meaning
    // IDLE  | ready for a command, last result still shown on res_data
    // EXEC  | ALU operands held steady while the ALU settles
    // RESP  | result presented until the consumer takes it
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_NOT   = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic [7:0] acc;
    logic [7:0] data_q;
    logic [2:0] op_q;
    logic       carry;
    logic       err;
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= 8'h00;
            data_q    <= 8'h00;
            op_q      <= 3'b000;
            carry     <= 1'b0;
            err       <= 1'b0;
            cnt       <= 4'd0;
            cmd_ready <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // ready rises on the first edge out of reset and stays up while idle
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        data_q    <= cmd_data;
                        cmd_ready <= 1'b0;
                        case (cmd_op)
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: begin
                                err   <= 1'b0;
                                cnt   <= CNT_INIT;
                                state <= EXEC;
                            end
                            OP_LOAD: begin
                                acc       <= cmd_data;
                                carry     <= 1'b0;
                                err       <= 1'b0;
                                res_valid <= 1'b1;
                                state     <= RESP;
                            end
                            OP_CLEAR: begin
                                acc       <= 8'h00;
                                carry     <= 1'b0;
                                err       <= 1'b0;
                                res_valid <= 1'b1;
                                state     <= RESP;
                            end
                            default: begin
                                err       <= 1'b1;
                                res_valid <= 1'b1;
                                state     <= RESP;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        acc       <= ula_s;
                        carry     <= (op_q == OP_AND || op_q == OP_NOT) ? 1'b0 : ula_cout;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ula_a    = acc;
    assign ula_b    = data_q;
    assign ula_x    = op_q;
    assign res_data = acc;
    assign res_cout = carry;
    assign res_zero = (acc == 8'h00);
    assign res_err  = err;

`ifdef ULA_CARRY_CHAIN_EN
    assign ula_cin = (state == EXEC) && (op_q == OP_ADD || op_q == OP_SUB) && carry;
`else
    assign ula_cin = 1'b0;
`endif

endmodule

// File: tb/tb_ula_8_bits_controller.sv
// Randomized self-checking bench for ula_8_bits_controller with a behavioural ALU and
// accumulator model; a second instance with WAIT_CYCLES=3 covers reset during EXEC.
module tb_ula_8_bits_controller;

`ifdef ULA_CARRY_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif
    localparam int W3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0, cmd_ready, ula_cin, ula_cout, res_valid, res_ready = 1'b0;
    logic       res_cout, res_zero, res_err;
    logic [2:0] cmd_op = 3'b000, ula_x;
    logic [7:0] cmd_data = 8'h00, ula_a, ula_b, ula_s, res_data;

    logic       v3 = 1'b0, cmd_ready3, ula_cin3, ula_cout3, res_valid3, rr3 = 1'b0;
    logic       res_cout3, res_zero3, res_err3;
    logic [2:0] op3 = 3'b000, ula_x3;
    logic [7:0] d3 = 8'h00, ula_a3, ula_b3, ula_s3, res_data3;

    int checks = 0;
    int passes = 0;
    logic [7:0] acc_m = 8'h00;
    logic       c_m = 1'b0;

    // External ALU; logic ops return a junk carry so the controller's masking is visible.
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] x, input logic cin);
        logic [8:0] r;
        case (x)
            3'd0: r = {1'b0, a} + {1'b0, b} + {8'h00, cin};
            3'd1: begin r[7:0] = a - b - {7'h00, cin}; r[8] = ({1'b0, a} < ({1'b0, b} + {8'h00, cin})); end
            3'd2: r = {1'b1, a & b};
            3'd3: r = {^(a | b), a | b};
            3'd4: r = {1'b1, ~a};
            default: r = 9'h1A5;
        endcase
        return r;
    endfunction

    assign {ula_cout, ula_s}   = alu_f(ula_a, ula_b, ula_x, ula_cin);
    assign {ula_cout3, ula_s3} = alu_f(ula_a3, ula_b3, ula_x3, ula_cin3);

    ula_8_bits_controller dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .ula_a(ula_a), .ula_b(ula_b), .ula_x(ula_x),
        .ula_cin(ula_cin), .ula_s(ula_s), .ula_cout(ula_cout), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_cout(res_cout),
        .res_zero(res_zero), .res_err(res_err)
    );

    ula_8_bits_controller #(.WAIT_CYCLES(W3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v3), .cmd_ready(cmd_ready3),
        .cmd_op(op3), .cmd_data(d3), .ula_a(ula_a3), .ula_b(ula_b3), .ula_x(ula_x3),
        .ula_cin(ula_cin3), .ula_s(ula_s3), .ula_cout(ula_cout3), .res_valid(res_valid3),
        .res_ready(rr3), .res_data(res_data3), .res_cout(res_cout3),
        .res_zero(res_zero3), .res_err(res_err3)
    );

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); else passes++;
        checks++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid got %b exp 0", res_valid); else passes++;
        checks++; if (res_data !== 8'h00) $display("FAIL rst_res_data got %h exp 00", res_data); else passes++;
        checks++; if ({res_cout, res_zero, res_err} !== 3'b010) $display("FAIL rst_flags got %b exp 010", {res_cout, res_zero, res_err}); else passes++;
        checks++; if ({ula_a, ula_b, ula_x, ula_cin} !== 20'h0) $display("FAIL rst_ula got %h exp 0", {ula_a, ula_b, ula_x, ula_cin}); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_ready_before_edge got %b exp 0", cmd_ready); else passes++;
        @(posedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready_after_edge got %b exp 1", cmd_ready); else passes++;
    endtask

    // One command through dut: model prediction, latency, EXEC stability, backpressure, release.
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] d, input int hold);
        logic [7:0] ea;
        logic       ec, ecin, eerr;
        int         s, lat, exp_lat;
        ecin = CHAIN && (op == 3'd0 || op == 3'd1) && c_m;
        eerr = 1'b0;
        exp_lat = (op <= 3'd4) ? 1 : 0;
        ec = 1'b0;
        ea = acc_m;
        case (op)
            3'd0: begin s = int'(acc_m) + int'(d) + int'(ecin); ea = 8'(s % 256); ec = (s > 255); end
            3'd1: begin s = int'(acc_m) - int'(d) - int'(ecin); ea = 8'((s + 256) % 256); ec = (s < 0); end
            3'd2: ea = acc_m & d;
            3'd3: begin ea = acc_m | d; ec = ^ea; end
            3'd4: ea = ~acc_m;
            3'd5: ea = d;
            3'd6: ea = 8'h00;
            default: begin ec = c_m; eerr = 1'b1; end
        endcase
        @(negedge clk);
        lat = 0;
        while (cmd_ready !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (cmd_ready !== 1'b1) $display("FAIL wait_ready got %b exp 1", cmd_ready); else passes++;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_data = 8'($urandom);
        lat = 0;
        while (res_valid !== 1'b1 && lat < 20) begin
            checks++; if ({ula_a, ula_b, ula_x} !== {acc_m, d, op}) $display("FAIL exec_operands got %h exp %h", {ula_a, ula_b, ula_x}, {acc_m, d, op}); else passes++;
            checks++; if (ula_cin !== ecin) $display("FAIL exec_cin got %b exp %b", ula_cin, ecin); else passes++;
            checks++; if (cmd_ready !== 1'b0) $display("FAIL exec_ready got %b exp 0", cmd_ready); else passes++;
            @(posedge clk);
            #1;
            lat++;
            cmd_op = 3'($urandom); cmd_data = 8'($urandom);
        end
        checks++; if (lat != exp_lat) $display("FAIL latency op=%0d got %0d exp %0d", op, lat, exp_lat); else passes++;
        checks++; if (res_data !== ea) $display("FAIL res_data op=%0d got %h exp %h", op, res_data, ea); else passes++;
        checks++; if ({res_cout, res_zero, res_err} !== {ec, ea == 8'h00, eerr}) $display("FAIL res_flags op=%0d got %b exp %b", op, {res_cout, res_zero, res_err}, {ec, ea == 8'h00, eerr}); else passes++;
        acc_m = ea;
        c_m = ec;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_op = 3'($urandom); cmd_data = 8'($urandom);
            @(posedge clk);
            #1;
            checks++; if ({res_valid, res_data, res_err} !== {1'b1, ea, eerr}) $display("FAIL hold_result got %h exp %h", {res_valid, res_data, res_err}, {1'b1, ea, eerr}); else passes++;
            checks++; if (cmd_ready !== 1'b0) $display("FAIL hold_ready got %b exp 0", cmd_ready); else passes++;
        end
        cmd_valid = (hold > 0);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        checks++; if ({res_valid, cmd_ready} !== 2'b01) $display("FAIL release got %b exp 01", {res_valid, cmd_ready}); else passes++;
    endtask

    task automatic test_directed();
        do_cmd(3'd5, 8'h83, 0);
        do_cmd(3'd0, 8'h01, 0);
        do_cmd(3'd5, 8'h92, 0);
        do_cmd(3'd1, 8'h06, 0);
        do_cmd(3'd4, 8'h3C, 0);
        do_cmd(3'd5, 8'hFF, 0);
        do_cmd(3'd0, 8'h01, 0);
        do_cmd(3'd0, 8'h05, 0);
        do_cmd(3'd5, 8'h5A, 0);
        do_cmd(3'd7, 8'h33, 0);
        do_cmd(3'd2, 8'hFF, 0);
        do_cmd(3'd6, 8'h44, 0);
    endtask

    task automatic test_backpressure();
        do_cmd(3'd5, 8'h70, 0);
        do_cmd(3'd3, 8'h0F, 5);
        do_cmd(3'd0, 8'h01, 5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            do_cmd(3'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 3)));
    endtask

    task automatic test_reset_mid_exec();
        int lat;
        @(negedge clk);
        v3 = 1'b1; op3 = 3'd5; d3 = 8'h77;
        @(posedge clk);
        #1;
        v3 = 1'b0; rr3 = 1'b1;
        checks++; if ({res_valid3, res_data3} !== {1'b1, 8'h77}) $display("FAIL w3_load got %h exp 177", {res_valid3, res_data3}); else passes++;
        @(posedge clk);
        #1;
        rr3 = 1'b0;
        @(negedge clk);
        v3 = 1'b1; op3 = 3'd0; d3 = 8'h10;
        @(posedge clk);
        #1;
        v3 = 1'b0;
        @(posedge clk);
        #1;
        checks++; if ({res_valid3, ula_a3, ula_b3} !== {1'b0, 8'h77, 8'h10}) $display("FAIL w3_exec got %h exp 07710", {res_valid3, ula_a3, ula_b3}); else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({cmd_ready3, res_valid3, res_data3, res_cout3, res_zero3, res_err3} !== {2'b00, 8'h00, 3'b010}) $display("FAIL w3_rst_res got %h exp 2", {cmd_ready3, res_valid3, res_data3, res_cout3, res_zero3, res_err3}); else passes++;
        checks++; if ({ula_a3, ula_b3, ula_x3, ula_cin3} !== 20'h0) $display("FAIL w3_rst_ula got %h exp 0", {ula_a3, ula_b3, ula_x3, ula_cin3}); else passes++;
        acc_m = 8'h00;
        c_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({cmd_ready3, ula_a3} !== {1'b1, 8'h00}) $display("FAIL w3_after_rst got %h exp 100", {cmd_ready3, ula_a3}); else passes++;
        @(negedge clk);
        v3 = 1'b1; op3 = 3'd0; d3 = 8'h10;
        @(posedge clk);
        #1;
        v3 = 1'b0;
        lat = 0;
        while (res_valid3 !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != W3) $display("FAIL w3_latency got %0d exp %0d", lat, W3); else passes++;
        checks++; if (res_data3 !== 8'h10) $display("FAIL w3_sum got %h exp 10", res_data3); else passes++;
        do_cmd(3'd0, 8'h21, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
